// File: rtl/mem_wb_stage_if.sv
// Memory->Writeback boundary bus: M-stage payload and hazard controls in, W-stage state out.
interface mem_wb_stage_if #(parameter int XLEN = 32);
  logic            StallW;
  logic            FlushW;
  logic            ValidM;
  logic            RegWriteM;
  logic [1:0]      ResultSrcM;
  logic [2:0]      Funct3M;
  logic [XLEN-1:0] ALUResultM;
  logic [XLEN-1:0] RD;
  logic [4:0]      RdM;
  logic [XLEN-1:0] PCPlus4M;

  logic            ValidW;
  logic            RegWriteW;
  logic [4:0]      RdW;
  logic [XLEN-1:0] ResultW;
  logic [XLEN-1:0] PCPlus4W;
  logic            MisalignW;
  logic [63:0]     InstretW;

  modport master (
    output StallW, FlushW, ValidM, RegWriteM, ResultSrcM, Funct3M,
           ALUResultM, RD, RdM, PCPlus4M,
    input  ValidW, RegWriteW, RdW, ResultW, PCPlus4W, MisalignW, InstretW
  );

  modport slave (
    input  StallW, FlushW, ValidM, RegWriteM, ResultSrcM, Funct3M,
           ALUResultM, RD, RdM, PCPlus4M,
    output ValidW, RegWriteW, RdW, ResultW, PCPlus4W, MisalignW, InstretW
  );
endinterface

// File: rtl/mem_wb_stage.sv
// RV32I M->W pipeline register: load formatting, misalign detect, result select, stall/flush.
// MEM_WB_INSTRET_EN adds a 64-bit retired-instruction counter; otherwise InstretW is tied to zero.
module mem_wb_stage #(
  parameter int XLEN = 32
) (
  input logic          CLK,
  input logic          RST_N,
  mem_wb_stage_if.slave bus
);

  logic [1:0]      off;
  logic [7:0]      ld_byte;
  logic [15:0]     ld_half;
  logic [XLEN-1:0] ld_data;
  logic [XLEN-1:0] result_d;
  logic            is_load;
  logic            misalign_d;
  logic            we_d;

  logic            valid_q;
  logic            we_q;
  logic            misalign_q;
  logic [4:0]      rd_q;
  logic [XLEN-1:0] result_q;
  logic [XLEN-1:0] pc4_q;

  assign off     = bus.ALUResultM[1:0];
  assign is_load = (bus.ResultSrcM == 2'b01);

  always_comb begin
    ld_byte = bus.RD[7:0];
    case (off)
      2'd1:    ld_byte = bus.RD[15:8];
      2'd2:    ld_byte = bus.RD[23:16];
      2'd3:    ld_byte = bus.RD[31:24];
      default: ld_byte = bus.RD[7:0];
    endcase
    ld_half = off[1] ? bus.RD[31:16] : bus.RD[15:0];
  end

  // Reserved widths (011/110/111) fall through to the full word.
  always_comb begin
    ld_data = bus.RD;
    case (bus.Funct3M)
      3'b000:  ld_data = {{(XLEN-8){ld_byte[7]}}, ld_byte};
      3'b100:  ld_data = {{(XLEN-8){1'b0}}, ld_byte};
      3'b001:  ld_data = {{(XLEN-16){ld_half[15]}}, ld_half};
      3'b101:  ld_data = {{(XLEN-16){1'b0}}, ld_half};
      default: ld_data = bus.RD;
    endcase
  end

  // Funct3[1:0]=01 is a halfword, Funct3[1]=1 is a word-wide access.
  always_comb begin
    misalign_d = 1'b0;
    if (is_load) begin
      if (bus.Funct3M[1:0] == 2'b01) misalign_d = off[0];
      else if (bus.Funct3M[1])       misalign_d = (off != 2'b00);
    end
  end

  always_comb begin
    result_d = bus.ALUResultM;
    case (bus.ResultSrcM)
      2'b01:   result_d = ld_data;
      2'b10:   result_d = bus.PCPlus4M;
      default: result_d = bus.ALUResultM;
    endcase
  end

  assign we_d = bus.ValidM & bus.RegWriteM & ~misalign_d & (bus.RdM != 5'd0);

  // A bubble (flush or ValidM=0) zeroes control, while data/PC+4 keep flowing on a normal load.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      valid_q    <= 1'b0;
      we_q       <= 1'b0;
      misalign_q <= 1'b0;
      rd_q       <= 5'd0;
      result_q   <= '0;
      pc4_q      <= '0;
    end else if (bus.FlushW) begin
      valid_q    <= 1'b0;
      we_q       <= 1'b0;
      misalign_q <= 1'b0;
      rd_q       <= 5'd0;
    end else if (!bus.StallW) begin
      valid_q    <= bus.ValidM;
      we_q       <= we_d;
      misalign_q <= bus.ValidM & misalign_d;
      rd_q       <= bus.ValidM ? bus.RdM : 5'd0;
      result_q   <= result_d;
      pc4_q      <= bus.PCPlus4M;
    end
  end

`ifdef MEM_WB_INSTRET_EN
  logic [63:0] instret_q;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)
      instret_q <= 64'd0;
    else if (bus.ValidM && !bus.StallW && !bus.FlushW)
      instret_q <= instret_q + 64'd1;
  end

  assign bus.InstretW = instret_q;
`else
  assign bus.InstretW = 64'h0;
`endif

  assign bus.ValidW    = valid_q;
  assign bus.RegWriteW = we_q;
  assign bus.MisalignW = misalign_q;
  assign bus.RdW       = rd_q;
  assign bus.ResultW   = result_q;
  assign bus.PCPlus4W  = pc4_q;

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- Memory/Writeback boundary of the 5-stage RV32I pipeline.
- Consumes the Memory stage outputs (pass-through controls, ALU result, raw data-memory read word, Rd, PC+4) and registers them into the W stage.
- Formats sub-word loads and selects the final writeback result.
- Supports stall/flush from the hazard unit and flags misaligned loads.

Parameters:
- XLEN, 32, datapath width; only 32 is supported.

Ports:
- CLK  in  1  pipeline clock, rising edge
- RST_N  in  1  asynchronous active-low reset
- StallW  in  1  hold all W registers
- FlushW  in  1  load a bubble into W
- ValidM  in  1  M-stage slot holds a real instruction
- RegWriteM  in  1  instruction writes Rd
- ResultSrcM  in  2  00 ALU, 01 load, 10 PC+4, 11 treated as ALU
- Funct3M  in  3  load width/sign (000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU)
- ALUResultM  in  32  address / ALU result
- RD  in  32  raw word from data memory, combinational for the current ALUResultM
- RdM  in  5  destination register
- PCPlus4M  in  32  PC+4 of the instruction
- ValidW  out  1  W slot holds a real instruction
- RegWriteW  out  1  register-file write enable
- RdW  out  5  register-file write address
- ResultW  out  32  register-file write data, also the WB forwarding source
- PCPlus4W  out  32  registered PC+4
- MisalignW  out  1  the instruction in W was a misaligned load
- InstretW  out  64  retired-instruction count (see Optional Feature)

Behaviour:
- **Latency:** 1 cycle. Inputs sampled at a CLK rising edge appear on outputs after that edge. No combinational path from any input to any output.
- **Reset:** while RST_N=0, asynchronously:
  - ValidW, RegWriteW, MisalignW = 0
  - RdW = 0; ResultW = 0; PCPlus4W = 0; InstretW = 0
  - Deassertion takes effect at the next edge; no handshake.
- **Edge priority:** FlushW > StallW > normal load.
  - Flush: ValidW=0, RegWriteW=0, MisalignW=0, RdW=0. ResultW and PCPlus4W may hold.
  - Stall: every register holds, counter included.
  - Flush+Stall together: flush wins.
- **Load extraction** (ResultSrcM=01), byte offset off = ALUResultM[1:0]:
  - LB/LBU: byte RD[8*off+7:8*off], sign- or zero-extended.
  - LH/LHU: halfword at off[1]*16, sign- or zero-extended.
  - LW: RD unchanged.
  - Funct3 011/110/111: treated as LW.
- **Misalign detect** (ResultSrcM=01 only): LH/LHU with off[0]=1, or LW with off≠0.
  - On detect: MisalignW=1 and RegWriteW=0. ResultW still holds the formatted, unrotated data.
- **Write enable:** RegWriteW = ValidM & RegWriteM & ~misalign & (RdM≠0). Writes to x0 are never asserted.
- **Result select:**
  - ResultSrcM=00 or 11: ResultW = ALUResultM.
  - ResultSrcM=10: ResultW = PCPlus4M.
- **Invalid slot:** ValidM=0 loads as a bubble (same outputs as flush) but still captures PCPlus4M and ResultW.
- **Counter:** InstretW increments by 1 on each edge where ValidM=1, StallW=0, FlushW=0. Misaligned loads count. Wraps from 2^64−1 to 0.
- **Reset mid-operation:** clears immediately regardless of StallW/FlushW.

Optional Feature:
- Macro: MEM_WB_INSTRET_EN.
- Defined: 64-bit InstretW counter as above.
- Undefined: no counter flops; InstretW tied to 64'h0.
- All other behaviour is identical in both builds.

Test Plan:
- LB sign-extend: ValidM=1, RegWriteM=1, ResultSrcM=01, Funct3M=000, ALUResultM=0x102, RD=0x12_80_34_56, RdM=5 -> next cycle ResultW=0xFFFFFF80, RegWriteW=1, RdW=5, MisalignW=0.
- LHU at off=2, RD=0xBEEF1234 -> ResultW=0x0000BEEF.
- Misaligned LH: LH at off=1 -> MisalignW=1, RegWriteW=0, ValidW=1.
- x0 suppression: ResultSrcM=10, PCPlus4M=0x40, RdM=0 -> ResultW=0x40, RegWriteW=0.
- Stall/flush ordering: StallW=1 for 3 cycles with changing inputs -> outputs and InstretW frozen. Then FlushW=1 with StallW=1 -> ValidW=0, RegWriteW=0.
- Reset and counter wrap:
  - Drive 10 valid instructions, then pull RST_N low mid-cycle -> all outputs 0 immediately, without waiting for a clock edge.
  - With MEM_WB_INSTRET_EN defined, force the counter to 2^64−1 and retire 1 instruction -> InstretW=0.
